// File: rtl/regex_stream_driver.sv
// Feeds a character stream to a per-character regex engine and forwards its match results.
// Define REGEX_DRV_WATCHDOG_EN to add the eng_rdy watchdog and the timeout_err output.
//
// state | meaning
// IDLE  | waiting for a character beat (in_ready high)
// PULSE | holding eng_reset high for RESET_CYCLES cycles
// WAIT  | waiting for eng_rdy from the engine
// EMIT  | presenting a match on res_* until res_ready
// DONE  | one-cycle end-of-string pulse, clears per-string state
module regex_stream_driver #(
    parameter int RESET_CYCLES   = 2,
    parameter int POS_W          = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             eng_reset,
    output logic [7:0]       eng_char,
    output logic             eng_last,
    input  logic             eng_rdy,
    input  logic             eng_match,
    input  logic [POS_W-1:0] eng_start_pos,
    input  logic [POS_W-1:0] eng_end_pos,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [POS_W-1:0] res_start,
    output logic [POS_W-1:0] res_end,
    output logic             done,
    output logic [31:0]      char_count
`ifdef REGEX_DRV_WATCHDOG_EN
    ,
    output logic             timeout_err
`endif
);

    if (RESET_CYCLES < 1 || RESET_CYCLES > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("regex_stream_driver: parameter out of legal range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [3:0] PULSE_LOAD = 4'(RESET_CYCLES - 1);

    state_t           r_state;
    logic             r_in_ready;
    logic             r_eng_reset;
    logic [7:0]       r_eng_char;
    logic             r_eng_last;
    logic             r_flush;
    logic             r_res_valid;
    logic [POS_W-1:0] r_res_start;
    logic [POS_W-1:0] r_res_end;
    logic             r_done;
    logic [31:0]      r_char_count;
    logic [3:0]       r_pulse_cnt;
    logic             w_result_done;

`ifdef REGEX_DRV_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] r_wd_cnt;
    logic            r_timeout;
    assign timeout_err = r_timeout;
`endif

    // A result is finished either by a no-match rdy or by the EMIT handshake.
    assign w_result_done = ((r_state == S_WAIT) && eng_rdy && !eng_match) ||
                           ((r_state == S_EMIT) && res_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_in_ready   <= 1'b1;
            r_eng_reset  <= 1'b0;
            r_eng_char   <= 8'd0;
            r_eng_last   <= 1'b0;
            r_flush      <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_start  <= '0;
            r_res_end    <= '0;
            r_done       <= 1'b0;
            r_char_count <= 32'd0;
            r_pulse_cnt  <= 4'd0;
`ifdef REGEX_DRV_WATCHDOG_EN
            r_wd_cnt     <= '0;
            r_timeout    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_in_ready   <= 1'b0;
                        r_eng_reset  <= 1'b1;
                        r_eng_char   <= in_data;
                        r_eng_last   <= 1'b0;
                        r_flush      <= in_last;
                        r_char_count <= r_char_count + 32'd1;
                        r_pulse_cnt  <= PULSE_LOAD;
                        r_state      <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    if (r_pulse_cnt == 4'd0) begin
                        r_eng_reset <= 1'b0;
                        r_state     <= S_WAIT;
`ifdef REGEX_DRV_WATCHDOG_EN
                        r_wd_cnt    <= WD_LOAD;
`endif
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt - 4'd1;
                    end
                end
                S_WAIT: begin
                    if (eng_rdy && eng_match) begin
                        r_res_start <= eng_start_pos;
                        r_res_end   <= eng_end_pos;
                        r_res_valid <= 1'b1;
                        r_state     <= S_EMIT;
                    end
`ifdef REGEX_DRV_WATCHDOG_EN
                    else if (!eng_rdy) begin
                        if (r_wd_cnt == '0) begin
                            r_timeout <= 1'b1;
                            r_flush   <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_wd_cnt <= r_wd_cnt - 1'b1;
                        end
                    end
`endif
                end
                S_EMIT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_eng_last   <= 1'b0;
                    r_char_count <= 32'd0;
                    r_in_ready   <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase

            // The flush trigger re-runs the engine on the last character with eng_last set.
            if (w_result_done) begin
                if (r_flush) begin
                    r_flush      <= 1'b0;
                    r_eng_last   <= 1'b1;
                    r_char_count <= r_char_count + 32'd1;
                    r_eng_reset  <= 1'b1;
                    r_pulse_cnt  <= PULSE_LOAD;
                    r_state      <= S_PULSE;
                end else if (r_eng_last) begin
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end else begin
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
            end
        end
    end

    // Reset reaches in_ready/eng_reset directly so the engine is cleared in the reset cycle itself.
    assign in_ready   = r_in_ready & ~reset;
    assign eng_reset  = r_eng_reset | reset;
    assign eng_char   = r_eng_char;
    assign eng_last   = r_eng_last;
    assign res_valid  = r_res_valid;
    assign res_start  = r_res_start;
    assign res_end    = r_res_end;
    assign done       = r_done;
    assign char_count = r_char_count;

endmodule

// File: tb/tb_regex_stream_driver.sv
// Bench for regex_stream_driver: directed scenarios plus random strings against a string-level model.
module tb_regex_stream_driver;

    localparam int RC    = 2;
    localparam int PW    = 32;
    localparam int TO    = 16;
    localparam int LIMIT = 400;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          in_last;
    logic          eng_reset;
    logic [7:0]    eng_char;
    logic          eng_last;
    logic          eng_rdy;
    logic          eng_match;
    logic [PW-1:0] eng_start_pos;
    logic [PW-1:0] eng_end_pos;
    logic          res_valid;
    logic          res_ready;
    logic [PW-1:0] res_start;
    logic [PW-1:0] res_end;
    logic          done;
    logic [31:0]   char_count;
`ifdef REGEX_DRV_WATCHDOG_EN
    logic          timeout_err;
`endif

    regex_stream_driver #(
        .RESET_CYCLES  (RC),
        .POS_W         (PW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .eng_reset    (eng_reset),
        .eng_char     (eng_char),
        .eng_last     (eng_last),
        .eng_rdy      (eng_rdy),
        .eng_match    (eng_match),
        .eng_start_pos(eng_start_pos),
        .eng_end_pos  (eng_end_pos),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_start    (res_start),
        .res_end      (res_end),
        .done         (done),
        .char_count   (char_count)
`ifdef REGEX_DRV_WATCHDOG_EN
        ,
        .timeout_err  (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          match;
        logic [PW-1:0] s;
        logic [PW-1:0] e;
        int            delay;
    } resp_t;
    typedef struct {
        logic [7:0] c;
        logic       last;
    } trig_t;
    typedef struct {
        logic [PW-1:0] s;
        logic [PW-1:0] e;
    } res_t;

    resp_t resp_q[$];
    trig_t trig_q[$];
    res_t  res_q[$];
    int    plen_q[$];
    int    done_cnt = 0;
    bit    rdy_always = 1'b0;
    bit    rr_rand = 1'b0;
    logic  rr_fixed = 1'b1;
    int    vectors = 0;
    int    miscompares = 0;

    logic [7:0] s_chars[8];
    resp_t      s_resp[9];
    int         s_n;

    function automatic resp_t mk(input logic m, input logic [PW-1:0] s, input logic [PW-1:0] e,
                                 input int d);
        resp_t r;
        r.match = m;
        r.s     = s;
        r.e     = e;
        r.delay = d;
        return r;
    endfunction

    // Engine model: takes one response per trigger, raises rdy `delay` cycles into WAIT, holds it.
    initial begin : engine
        resp_t cur;
        int    wcnt;
        bit    armed;
        logic  prev_er;
        eng_rdy = 1'b0; eng_match = 1'b0; eng_start_pos = '0; eng_end_pos = '0;
        res_ready = 1'b1; armed = 1'b0; wcnt = 0; prev_er = 1'b1;
        cur = mk(1'b0, '0, '0, 0);
        forever begin
            @(posedge clk); #1;
            res_ready = rr_rand ? ($urandom_range(0, 1) == 1) : rr_fixed;
            if (reset) begin
                armed   = 1'b0;
                eng_rdy = 1'b0;
            end else if (eng_reset) begin
                eng_rdy = rdy_always;
                if (!prev_er) begin
                    cur = (resp_q.size() > 0) ? resp_q.pop_front() : mk(1'b0, '0, '0, 0);
                    eng_match = cur.match; eng_start_pos = cur.s; eng_end_pos = cur.e;
                    armed = 1'b1; wcnt = 0;
                end
            end else if (armed) begin
                if (wcnt >= cur.delay) begin
                    eng_rdy = 1'b1;
                    armed   = 1'b0;
                end else begin
                    wcnt++;
                end
            end
            prev_er = eng_reset;
        end
    end

    // Observer: records triggers, pulse widths, result handshakes and done pulses.
    initial begin : monitor
        logic prev_er;
        int   plen;
        bit   inp;
        trig_t t;
        res_t  r;
        prev_er = 1'b1; plen = 0; inp = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                inp = 1'b0;
            end else begin
                if (eng_reset && !prev_er) begin
                    t.c = eng_char; t.last = eng_last;
                    trig_q.push_back(t);
                    inp = 1'b1; plen = 0;
                end
                if (inp) begin
                    if (eng_reset) plen++;
                    else begin
                        plen_q.push_back(plen);
                        inp = 1'b0;
                    end
                end
                if (res_valid && res_ready) begin
                    r.s = res_start; r.e = res_end;
                    res_q.push_back(r);
                end
                if (done) done_cnt++;
            end
            prev_er = eng_reset;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        resp_q.delete(); trig_q.delete(); res_q.delete(); plen_q.delete();
        done_cnt = 0;
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (!in_ready && k < LIMIT) begin tick(); k++; end
        check(tag, (k < LIMIT), 1'b1);
    endtask

    task automatic wait_res_valid(input string tag);
        int k = 0;
        while (!res_valid && k < LIMIT) begin tick(); k++; end
        check(tag, (k < LIMIT), 1'b1);
    endtask

    task automatic wait_done(input int d0, input string tag);
        int k = 0;
        while (done_cnt == d0 && k < LIMIT) begin tick(); k++; end
        check(tag, (k < LIMIT), 1'b1);
    endtask

    task automatic send_char(input logic [7:0] c, input logic l);
        in_valid = 1'b1; in_data = c; in_last = l;
        wait_idle("accept_wait");
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Runs s_chars[0..s_n-1] as one string with responses s_resp[0..s_n] and checks it end to end.
    task automatic run_string();
        int   d0;
        res_t exp_res[$];
        res_t r;
        d0 = done_cnt;
        trig_q.delete(); res_q.delete(); plen_q.delete();
        for (int i = 0; i <= s_n; i++) resp_q.push_back(s_resp[i]);
        for (int i = 0; i < s_n; i++) begin
            wait_idle("str_idle");
            check("str_cc_before", char_count, i);
            send_char(s_chars[i], (i == s_n - 1));
        end
        wait_done(d0, "str_done_wait");
        tick(); tick();
        check("str_trig_cnt", trig_q.size(), s_n + 1);
        for (int i = 0; i <= s_n && i < trig_q.size(); i++) begin
            check("str_trig_char", trig_q[i].c, (i < s_n) ? s_chars[i] : s_chars[s_n - 1]);
            check("str_trig_last", trig_q[i].last, (i == s_n));
        end
        foreach (plen_q[i]) check("str_pulse_len", plen_q[i], RC);
        for (int i = 0; i <= s_n; i++) begin
            if (s_resp[i].match) begin
                r.s = s_resp[i].s; r.e = s_resp[i].e;
                exp_res.push_back(r);
            end
        end
        check("str_res_cnt", res_q.size(), exp_res.size());
        for (int i = 0; i < exp_res.size() && i < res_q.size(); i++) begin
            check("str_res_start", res_q[i].s, exp_res[i].s);
            check("str_res_end", res_q[i].e, exp_res[i].e);
        end
        check("str_done_once", done_cnt, d0 + 1);
        check("str_cc_after", char_count, 0);
        check("str_in_ready", in_ready, 1'b1);
    endtask

    initial begin : stim
        reset = 1'b1; in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0;
        tick();
        tick();
        // reset values
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_eng_reset", eng_reset, 1'b1);
        check("rst_eng_char", eng_char, 8'd0);
        check("rst_eng_last", eng_last, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_pos", {res_start, res_end}, 64'd0);
        check("rst_done", done, 1'b0);
        check("rst_char_count", char_count, 32'd0);
`ifdef REGEX_DRV_WATCHDOG_EN
        check("rst_timeout", timeout_err, 1'b0);
`endif
        resp_q.delete(); trig_q.delete(); res_q.delete(); plen_q.delete(); done_cnt = 0;
        reset = 1'b0;
        tick();
        check("idle_in_ready", in_ready, 1'b1);
        check("idle_eng_reset", eng_reset, 1'b0);

        // single 'a', no last, no match
        resp_q.push_back(mk(1'b0, '0, '0, 3));
        send_char(8'h61, 1'b0);
        wait_idle("a_idle");
        check("a_pulse_cnt", plen_q.size(), 1);
        check("a_pulse_len", (plen_q.size() > 0) ? plen_q[0] : -1, RC);
        check("a_no_result", res_q.size(), 0);
        check("a_char_count", char_count, 32'd1);
        check("a_trig_char", (trig_q.size() > 0) ? trig_q[0].c : 8'h00, 8'h61);
        check("a_no_done", done_cnt, 0);

        // "ab", match only on the flush trigger
        do_reset();
        s_n = 2; s_chars[0] = 8'h61; s_chars[1] = 8'h62;
        s_resp[0] = mk(1'b0, '0, '0, 1);
        s_resp[1] = mk(1'b0, '0, '0, 2);
        s_resp[2] = mk(1'b1, 32'd0, 32'd1, 2);
        run_string();

        // result held with res_ready low
        do_reset();
        rr_fixed = 1'b0;
        resp_q.push_back(mk(1'b1, 32'h11, 32'h22, 1));
        resp_q.push_back(mk(1'b0, '0, '0, 0));
        send_char(8'h78, 1'b1);
        wait_res_valid("hold_rv_wait");
        for (int j = 0; j < 5; j++) begin
            check("hold_res_valid", res_valid, 1'b1);
            check("hold_res_start", res_start, 32'h11);
            check("hold_res_end", res_end, 32'h22);
            check("hold_in_ready", in_ready, 1'b0);
            tick();
        end
        check("hold_no_hs", res_q.size(), 0);
        rr_fixed = 1'b1;
        wait_done(0, "hold_done_wait");
        check("hold_one_res", res_q.size(), 1);
        check("hold_res_val", (res_q.size() > 0) ? {res_q[0].s, res_q[0].e} : 64'd0,
              {32'h11, 32'h22});

        // reset during WAIT
        do_reset();
        resp_q.push_back(mk(1'b1, 32'h5, 32'h6, 20));
        send_char(8'h77, 1'b0);
        for (int j = 0; j < RC + 2; j++) tick();
        check("rw_in_wait", eng_reset, 1'b0);
        reset = 1'b1;
        tick();
        check("rw_eng_reset", eng_reset, 1'b1);
        check("rw_res_valid", res_valid, 1'b0);
        check("rw_char_count", char_count, 32'd0);
        reset = 1'b0;
        tick();
        check("rw_in_ready", in_ready, 1'b1);
        check("rw_eng_reset_lo", eng_reset, 1'b0);
        for (int j = 0; j < 25; j++) tick();
        check("rw_no_late_res", res_valid, 1'b0);

        // reset during EMIT
        do_reset();
        rr_fixed = 1'b0;
        resp_q.push_back(mk(1'b1, 32'h7, 32'h8, 0));
        send_char(8'h65, 1'b0);
        wait_res_valid("re_rv_wait");
        reset = 1'b1;
        tick();
        check("re_eng_reset", eng_reset, 1'b1);
        check("re_res_valid", res_valid, 1'b0);
        check("re_char_count", char_count, 32'd0);
        reset = 1'b0;
        rr_fixed = 1'b1;
        tick();
        check("re_in_ready", in_ready, 1'b1);
        check("re_no_hs", res_q.size(), 0);

        // eng_rdy high throughout: capture only in the first WAIT cycle
        do_reset();
        rdy_always = 1'b1;
        resp_q.push_back(mk(1'b1, 32'd5, 32'd9, 0));
        send_char(8'h7a, 1'b0);
        for (int j = 0; j <= RC + 1; j++) begin
            check("early_res_valid", res_valid, (j == RC + 1));
            if (j < RC + 1) tick();
        end
        check("early_res_pos", {res_start, res_end}, {32'd5, 32'd9});
        wait_idle("early_idle");
        rdy_always = 1'b0;

`ifdef REGEX_DRV_WATCHDOG_EN
        begin
            int k;
            do_reset();
            resp_q.push_back(mk(1'b0, '0, '0, 1000000));
            send_char(8'h71, 1'b1);
            k = 0;
            while (eng_reset && k < LIMIT) begin tick(); k++; end
            check("wd_wait_entry", (k < LIMIT), 1'b1);
            for (int j = 0; j < TO - 1; j++) tick();
            check("wd_not_yet", timeout_err, 1'b0);
            tick();
            check("wd_timeout", timeout_err, 1'b1);
            wait_done(0, "wd_done_wait");
            for (int j = 0; j < 5; j++) tick();
            check("wd_sticky", timeout_err, 1'b1);
            check("wd_done_once", done_cnt, 1);
            check("wd_no_flush", trig_q.size(), 1);
            check("wd_no_res", res_q.size(), 0);
            do_reset();
            check("wd_cleared", timeout_err, 1'b0);
        end
`endif

        // random strings against the string-level model
        do_reset();
        rr_rand = 1'b1;
        for (int t = 0; t < 8; t++) begin
            s_n = $urandom_range(1, 4);
            for (int i = 0; i < s_n; i++) s_chars[i] = 8'($urandom_range(0, 255));
            for (int i = 0; i <= s_n; i++)
                s_resp[i] = mk(($urandom_range(0, 1) == 1), $urandom, $urandom,
                               $urandom_range(0, 4));
            run_string();
        end
        rr_rand = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regex_stream_driver.md
REGEX_STREAM_DRIVER -- requirements
Module: regex_stream_driver

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 2, the number of cycles eng_reset is held high per trigger (legal 1..15).
REQ-002 SHALL have parameter POS_W, default 32, the width of the position fields.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, the rdy watchdog limit (used only under REQ-030).
REQ-004 SHALL have ports: clk  in  1  clock; reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: in_valid  in  1  char beat valid; in_ready  out  1  char beat accepted; in_data  in  8  character; in_last  in  1  final character of string.
REQ-006 SHALL have ports: eng_reset  out  1  per-char engine trigger; eng_char  out  8  char to engine; eng_last  out  1  end-of-string flag to engine; eng_rdy  in  1  engine done; eng_match  in  1  match found; eng_start_pos, eng_end_pos  in  POS_W  match bounds.
REQ-007 SHALL have ports: res_valid  out  1  result valid; res_ready  in  1  result accepted; res_start, res_end  out  POS_W  match bounds; done  out  1  one-cycle end-of-string pulse; char_count  out  32  triggers issued in current string.

Function
REQ-008 SHALL implement FSM states IDLE, PULSE, WAIT, EMIT, DONE.
REQ-009 SHALL assert in_ready only in IDLE; a beat is accepted when in_valid and in_ready are both high on a rising edge.
REQ-010 SHALL, on acceptance, register eng_char=in_data, eng_last=0, latch flush_pending=in_last, increment char_count, and enter PULSE.
REQ-011 SHALL drive eng_reset high for exactly RESET_CYCLES cycles while in PULSE, then enter WAIT with eng_reset low.
REQ-012 SHALL hold eng_char and eng_last stable from PULSE entry until the next trigger begins.
REQ-013 SHALL ignore eng_rdy during PULSE; in WAIT it SHALL sample eng_rdy no earlier than the first cycle after eng_reset falls.
REQ-014 SHALL, on eng_rdy high in WAIT, capture eng_start_pos/eng_end_pos into res_start/res_end when eng_match is high and enter EMIT; when eng_match is low it SHALL skip EMIT.
REQ-015 SHALL hold res_valid high in EMIT with constant res_start/res_end until res_ready is high; res_valid drops the cycle after the handshake.
REQ-016 SHALL, after a result completes (EMIT handshake, or no match): if flush_pending, clear it, set eng_last=1 (eng_char unchanged), increment char_count, and re-enter PULSE (flush trigger); else if eng_last=1, enter DONE; else return to IDLE.
REQ-017 SHALL, in DONE, pulse done for one cycle, clear eng_last and char_count, and return to IDLE.
REQ-018 SHALL treat res_ready high while res_valid is low as no effect.
REQ-019 SHALL wrap char_count modulo 2^32 with no flag.
REQ-020 SHALL add no latency beyond: accept -> PULSE next cycle; eng_rdy -> EMIT or next state next cycle.

Reset
REQ-021 SHALL, on reset high at a rising edge, enter IDLE regardless of state, including mid-PULSE, mid-WAIT or mid-EMIT.
REQ-022 SHALL reset outputs to: in_ready=0 during reset cycle then 1 in IDLE, eng_reset=1, eng_char=0, eng_last=0, res_valid=0, res_start=0, res_end=0, done=0, char_count=0; flush_pending=0.
REQ-023 SHALL drive eng_reset=1 while reset is high, and low in IDLE thereafter, so the engine is also cleared.
REQ-024 SHALL drop any pending result on reset without a res_valid handshake.

Configuration
REQ-030 SHALL, with macro REGEX_DRV_WATCHDOG_EN defined, count WAIT cycles and, if eng_rdy is not seen within TIMEOUT_CYCLES, set sticky output timeout_err (1 bit, reset 0), skip EMIT and any flush, and enter DONE.
REQ-031 SHALL, without REGEX_DRV_WATCHDOG_EN, omit the timeout_err port and counter and wait in WAIT indefinitely.

Verification
REQ-040 Bench: 'a' with in_last=0, engine rdy 3 cycles after eng_reset falls, match=0 -> eng_reset high exactly 2 cycles, no res_valid, back to IDLE, char_count=1.
REQ-041 Bench: "ab" with in_last on 'b', engine matches on flush with start=0, end=1 -> three triggers, third with eng_last=1 and eng_char='b'; one result {0,1}; done pulses once; char_count returns to 0.
REQ-042 Bench: match result with res_ready held low 5 cycles -> res_valid high 5+ cycles, res_start/res_end constant, in_ready low throughout.
REQ-043 Bench: reset asserted during WAIT and again during EMIT -> next cycle IDLE, res_valid=0, char_count=0, eng_reset=1 during reset.
REQ-044 Bench (REGEX_DRV_WATCHDOG_EN, TIMEOUT_CYCLES=16): eng_rdy never asserted -> timeout_err=1 after 16 WAIT cycles, done pulses, timeout_err stays 1 until reset.
REQ-045 Bench: eng_rdy held high continuously, including through PULSE -> no result captured until first WAIT cycle after eng_reset falls.
